// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   state_t : arbiter FSM encoding (IDLE, BUSY, RESP)
//   owner_t : which requester owns the current memory transaction
//   PRIO_*  : arbitration mode selectors for PRIORITY_MODE
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int PRIO_RR   = 0;
    localparam int PRIO_DATA = 1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of memory_arbiter.
//   Instruction port : i_req, i_addr -> i_rdata, i_ack
//   Data port        : d_req, d_we, d_addr, d_wdata, d_wstrb -> d_rdata, d_ack
//   Shared status    : bus_err (qualifies whichever ack is pulsing)
//   Memory port      : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb <- mem_rdata, mem_ready
// Modports:
//   master : the arbiter itself (drives acks, read data and the memory request)
//   slave  : the environment (requesters and the memory)
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_ack;

    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wstrb;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_ack;

    logic                    bus_err;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ready;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ack,
        output bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ack,
        input  bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant between the instruction and data requesters.
//   req_i, req_d : pending requests
//   last_grant   : owner of the previous grant (round-robin history)
//   mode         : 0 = alternate on ties, 1 = data always wins ties
//   grant_valid  : at least one request pending
//   grant        : selected owner (meaningful only with grant_valid)
module rr_arbiter2
    import memory_bus_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    input  logic   mode,
    output logic   grant_valid,
    output owner_t grant
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant       = OWN_I;
        if (req_i && req_d) begin
            if (mode) begin
                grant = OWN_D;
            end else begin
                grant = (last_grant == OWN_D) ? OWN_I : OWN_D;
            end
        end else if (req_d) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and the
// load/store requesters. One transaction at a time: IDLE arbitrates and
// latches the winner's request, BUSY holds it on the memory port until
// mem_ready (or the timeout), RESP pulses the owner's ack for one cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : requester and memory signals (memory_arbiter_if.master)
// The bus interface instance must use the same ADDR_WIDTH/DATA_WIDTH.
module memory_arbiter
    import memory_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              reset,
    memory_arbiter_if.master  bus
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last BUSY cycle index before the transaction is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                state, state_nxt;
    owner_t                owner, last_grant, grant;
    logic                  grant_valid;
    logic [CNT_W-1:0]      cnt;
    logic                  timed_out;
    logic                  err_q;

    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [STRB_W-1:0]     mem_wstrb_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;

    rr_arbiter2 u_arb (
        .req_i       (bus.i_req),
        .req_d       (bus.d_req),
        .last_grant  (last_grant),
        .mode        (PRIORITY_MODE == PRIO_DATA),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // mem_ready in the final counted cycle still completes normally.
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST) && !bus.mem_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_valid) state_nxt = BUSY;
            BUSY:    if (bus.mem_ready || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only flops, so there is no path from req to the memory port.
    always_comb begin
        bus.mem_req   = (state == BUSY);
        bus.i_ack     = (state == RESP) && (owner == OWN_I);
        bus.d_ack     = (state == RESP) && (owner == OWN_D);
        bus.bus_err   = (state == RESP) && err_q;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.mem_wstrb = mem_wstrb_q;
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;
    end

    // Request latch, timeout counter and read-data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= OWN_I;
            last_grant  <= OWN_D;
            cnt         <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= '0;
                        err_q      <= 1'b0;
                        if (grant == OWN_D) begin
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            mem_wstrb_q <= bus.d_we ? bus.d_wstrb : '0;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.i_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Stores never disturb d_rdata, whether they complete or time out.
                    if (bus.mem_ready) begin
                        err_q <= 1'b0;
                        if (owner == OWN_I) begin
                            i_rdata_q <= bus.mem_rdata;
                        end else if (!mem_we_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        if (owner == OWN_I) begin
                            i_rdata_q <= '0;
                        end else if (!mem_we_q) begin
                            d_rdata_q <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a round-robin instance with a
// short timeout driven through a scoreboard and a memory model, plus a
// fixed-priority instance fed with continuous ties.
module tb_memory_arbiter;
    import memory_bus_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fbus ();

    memory_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(PRIO_RR), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    memory_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(PRIO_DATA), .TIMEOUT(4)
    ) dut_fp (
        .clk(clk), .reset(reset), .bus(fbus)
    );

    // Zero-wait memory for the fixed-priority instance.
    assign fbus.mem_ready = fbus.mem_req;
    assign fbus.mem_rdata = fbus.mem_addr ^ 32'hA5A5_0000;

    typedef struct {
        logic        own;      // 0 = instruction, 1 = data
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;    // expected mem_wstrb
        logic [31:0] mem_rd;   // word the memory model returns
        int          wait_c;   // BUSY cycles before ready; -1 = never
        logic [31:0] exp_rd;
        logic        exp_err;
    } txn_t;

    txn_t        sb[$];
    logic        fp_q[$];
    logic [31:0] i_model = '0;
    logic [31:0] d_model = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic own, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] mem_rd, input int wait_c);
        txn_t t;
        t.own     = own;
        t.we      = own & we;
        t.addr    = addr;
        t.wdata   = wdata;
        t.wstrb   = (own && we) ? wstrb : 4'h0;
        t.mem_rd  = mem_rd;
        t.wait_c  = wait_c;
        t.exp_err = (wait_c < 0);
        if (!own) begin
            i_model = t.exp_err ? 32'h0 : mem_rd;
            t.exp_rd = i_model;
        end else begin
            if (!we) d_model = t.exp_err ? 32'h0 : mem_rd;
            t.exp_rd = d_model;
        end
        sb.push_back(t);
    endtask

    // Memory model: checks the request against the scoreboard head on the
    // first BUSY cycle, checks it stays stable after, and answers after wait_c cycles.
    int          busy_cnt = 0;
    logic [31:0] snap_addr;
    logic [36:0] snap_rest;
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (sb.size() == 0) begin
                check("mem_req_unexpected", {63'h0, bus.mem_req}, 64'h0);
                bus.mem_ready = 1'b0;
                bus.mem_rdata = '0;
            end else begin
                if (busy_cnt == 0) begin
                    check("mem_addr", bus.mem_addr, sb[0].addr);
                    check("mem_we", bus.mem_we, sb[0].we);
                    check("mem_wstrb", bus.mem_wstrb, sb[0].wstrb);
                    if (sb[0].we) check("mem_wdata", bus.mem_wdata, sb[0].wdata);
                    snap_addr = bus.mem_addr;
                    snap_rest = {bus.mem_we, bus.mem_wstrb, bus.mem_wdata};
                end else begin
                    check("mem_addr_hold", bus.mem_addr, snap_addr);
                    check("mem_ctrl_hold", {bus.mem_we, bus.mem_wstrb, bus.mem_wdata}, snap_rest);
                end
                bus.mem_ready = (busy_cnt == sb[0].wait_c);
                bus.mem_rdata = bus.mem_ready ? sb[0].mem_rd : 32'hDEAD_BEEF;
                busy_cnt++;
            end
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            busy_cnt      = 0;
        end
    end

    // Ack monitor: every ack pops the scoreboard head.
    txn_t mt;
    always @(negedge clk) begin
        if (bus.i_ack || bus.d_ack) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", {62'h0, bus.i_ack, bus.d_ack}, 64'h0);
            end else begin
                mt = sb.pop_front();
                check("ack_owner", {bus.i_ack, bus.d_ack}, mt.own ? 2'b01 : 2'b10);
                check("rdata", mt.own ? bus.d_rdata : bus.i_rdata, mt.exp_rd);
                check("bus_err", bus.bus_err, mt.exp_err);
            end
        end
    end

    task automatic fetch_req(input logic [31:0] addr, output int lat);
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        lat = 0;
        while (!bus.i_ack && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.i_ack) check("i_ack_wait", {63'h0, bus.i_ack}, 64'h1);
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output int lat);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_wstrb = wstrb;
        lat = 0;
        while (!bus.d_ack && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.d_ack) check("d_ack_wait", {63'h0, bus.d_ack}, 64'h1);
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        sb.delete();
        i_model = '0;
        d_model = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int   lat_i, lat_d, acks;
        logic own;

        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;  bus.d_wstrb = '0;
        fbus.i_req = 1'b0; fbus.i_addr = '0;
        fbus.d_req = 1'b0; fbus.d_we = 1'b0; fbus.d_addr = '0; fbus.d_wdata = '0; fbus.d_wstrb = '0;

        repeat (2) @(negedge clk);
        check("rst_mem_req", {63'h0, bus.mem_req}, 64'h0);
        check("rst_flags", {61'h0, bus.i_ack, bus.d_ack, bus.bus_err}, 64'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // Fixed priority: both requests held across three ties -> D each time.
        repeat (3) fp_q.push_back(1'b1);
        fbus.i_req = 1'b1; fbus.i_addr = 32'h20;
        fbus.d_req = 1'b1; fbus.d_addr = 32'h40;
        acks = 0;
        for (int k = 0; k < 40 && acks < 3; k++) begin
            @(negedge clk);
            if (fbus.i_ack || fbus.d_ack) begin
                acks++;
                own = fp_q.pop_front();
                check("fp_owner", {fbus.i_ack, fbus.d_ack}, own ? 2'b01 : 2'b10);
                check("fp_rdata", fbus.d_rdata, 32'h40 ^ 32'hA5A5_0000);
            end
        end
        check("fp_acks", acks, 3);
        fbus.i_req = 1'b0;
        fbus.d_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("fp_quiet", {62'h0, fbus.i_ack, fbus.d_ack}, 64'h0);
        end

        // Single zero-wait fetch.
        expect_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0051_3093, 0);
        fetch_req(32'h10, lat_i);
        check("fetch_latency", lat_i, 2);

        // Store with three BUSY cycles; d_rdata must stay at its reset value.
        expect_txn(1'b1, 1'b1, 32'h100, 32'hCAFE_BABE, 4'b0011, 32'h1111_2222, 2);
        data_req(1'b1, 32'h100, 32'hCAFE_BABE, 4'b0011, lat_d);
        check("store_latency", lat_d, 4);

        // Load, then a store that must leave the loaded word in d_rdata.
        expect_txn(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'h1234_5678, 1);
        data_req(1'b0, 32'h200, 32'h0, 4'hF, lat_d);
        expect_txn(1'b1, 1'b1, 32'h204, 32'h0BAD_F00D, 4'b1100, 32'h0, 0);
        data_req(1'b1, 32'h204, 32'h0BAD_F00D, 4'b1100, lat_d);

        // Timeout: no ready -> error after four BUSY cycles.
        expect_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0, -1);
        data_req(1'b0, 32'h300, 32'h0, 4'h0, lat_d);
        check("timeout_latency", lat_d, 5);

        // Ready on the fourth BUSY cycle beats the timeout.
        expect_txn(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 32'h7777_8888, 3);
        data_req(1'b0, 32'h304, 32'h0, 4'h0, lat_d);
        check("late_ready_latency", lat_d, 5);

        // Round-robin ties from reset: I, D, then I again.
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            expect_txn(1'b0, 1'b0, 32'h40 + r, 32'h0, 4'h0, 32'hA000_0000 + r, 0);
            expect_txn(1'b1, 1'b0, 32'h80 + r, 32'h0, 4'h0, 32'hB000_0000 + r, 0);
            fork
                fetch_req(32'h40 + r, lat_i);
                data_req(1'b0, 32'h80 + r, 32'h0, 4'h0, lat_d);
            join
            check("tie_i_latency", lat_i, 2);
            check("tie_d_latency", lat_d, 5);
        end

        // Asynchronous reset in the middle of BUSY abandons the fetch silently.
        expect_txn(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 32'h0, -1);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_mem_req", {63'h0, bus.mem_req}, 64'h0);
        check("areset_ack", {62'h0, bus.i_ack, bus.d_ack}, 64'h0);
        check("areset_i_rdata", bus.i_rdata, 32'h0);
        bus.i_req = 1'b0;
        sb.delete();
        i_model = '0;
        d_model = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        expect_txn(1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 32'h00C0_FFEE, 0);
        fetch_req(32'h44, lat_i);
        check("post_reset_latency", lat_i, 2);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-ported 32-bit memory between the instruction-fetch requester and the load/store requester of the multicycle core.
- Grants one requester at a time and holds address, write data and strobes stable for the memory.
- Waits for memory ready, with a bounded timeout, then returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the control-unit-driven datapath and the memory/MMIO bus.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- PRIORITY_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority to D.
- TIMEOUT, 255, maximum BUSY cycles before an error response; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetched word; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for loads.
- d_rdata  out  DATA_WIDTH  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- bus_err  out  1  high with the ack pulse when the transaction timed out.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wstrb  out  DATA_WIDTH/8  memory byte strobes; 0 for reads.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion for the current request.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state=IDLE; timeout counter=0.
  - last_grant=D, so instruction fetch wins the first tie.
  - Reset mid-transaction abandons it silently; no ack is issued.
- FSM states: IDLE, BUSY, RESP, all transitions registered.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, latch the winner's addr/we/wdata/wstrb into mem_* registers, record owner, go to BUSY.
  - For an instruction grant: mem_we=0, mem_wstrb=0.
- Arbitration, both requesting:
  - PRIORITY_MODE=0: grant the requester not equal to last_grant.
  - PRIORITY_MODE=1: always grant D.
  - last_grant updates on every grant.
  - A single requester is always granted.
- BUSY:
  - mem_req=1; mem_* held constant.
  - On mem_ready=1: capture mem_rdata into the owner's rdata register, bus_err=0, go to RESP.
  - mem_ready in the same cycle mem_req first rises is legal and completes that cycle.
- Timeout:
  - Counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - If TIMEOUT!=0 and the count reaches TIMEOUT-1 with no ready: rdata=0, bus_err=1, go to RESP.
  - mem_ready on that same cycle wins: normal completion.
- RESP:
  - mem_req=0; the owner's ack=1 for exactly one cycle; bus_err as captured.
  - Non-owner ack stays 0.
  - Next state IDLE.
- Latency: minimum 2 cycles from request seen in IDLE to ack (IDLE→BUSY→RESP with zero-wait memory). Back-to-back throughput is one transaction per 3 cycles.
- Requester rules:
  - req, addr and data must stay stable until ack.
  - req must drop the cycle after ack, or IDLE starts a new transaction.
- A requester dropping req while BUSY does not cancel the transaction; the ack still pulses and may be ignored.
- i_rdata/d_rdata hold their last captured value outside the ack cycle.
- A store completes with rdata unchanged and ack/bus_err as normal.
- Outputs are registered; no combinational path from req to mem_*.

Decomposition:
- Package memory_bus_pkg:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1);
  - PRIO_RR=0, PRIO_DATA=1 constants.
- Sub-module rr_arbiter2 (combinational two-way grant from req_i, req_d, last_grant, mode). The FSM, timeout counter and datapath registers stay in memory_arbiter.

Test Plan:
- Single fetch, zero-wait: i_req=1, i_addr=0x0000_0010; mem_ready=1 on the first BUSY cycle with mem_rdata=0x0051_3093 → mem_addr=0x10, mem_we=0; i_ack one cycle later with i_rdata=0x0051_3093, bus_err=0; total 2 cycles.
- Store with wait states: d_req=1, d_we=1, d_addr=0x0000_0100, d_wdata=0xCAFE_BABE, d_wstrb=4'b0011; mem_ready after 3 BUSY cycles → mem_* stable for all 3 cycles, mem_wstrb=0011; then one d_ack, i_ack=0.
- Round-robin tie, PRIORITY_MODE=0: i_req and d_req both high from reset → I granted first, D second; a repeated tie grants I again.
- Fixed priority, PRIORITY_MODE=1: i_req and d_req both held high across 3 ties → D granted every time.
- Timeout, TIMEOUT=4: d_req load, mem_ready never asserted → d_ack with bus_err=1, d_rdata=0 after 4 BUSY cycles; ready on the 4th cycle instead → normal data, bus_err=0.
- Async reset mid-BUSY: assert reset=0 between clock edges → mem_req=0 immediately, no ack; after release, state IDLE and a new fetch completes normally.
